// File: rtl/counter_array_pkg.sv
// Package: counter_array_pkg
// Purpose: shared types and helpers for the counter_array_gen counter bank.
//   cnt_mode_t : per-channel behaviour on reaching the all-ones value
//                (CNT_WRAP rolls over to 0, CNT_SAT holds at max).
//   cnt_max()  : all-ones value for a counter of the given width (up to 64 bits).
package counter_array_pkg;

  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_t;

  localparam int unsigned CNT_MAX_W = 64;

  function automatic logic [CNT_MAX_W-1:0] cnt_max(input int unsigned width);
    logic [CNT_MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < CNT_MAX_W; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// Module: counter_channel
// Purpose: one WIDTH-bit unsigned up-counter with clear, load, enable,
//   wrap/saturate mode, one-cycle terminal-count pulse and sticky overflow.
// Ports:
//   c       in  clock, rising edge
//   rn      in  asynchronous reset, active-low
//   en      in  count enable
//   clr     in  synchronous clear (highest priority)
//   ld      in  synchronous load of ld_val (beats en)
//   ld_val  in  load value
//   sat     in  mode: 0 = wrap, 1 = saturate
//   ovf_clr in  clears the sticky overflow flag
//   cnt     out counter value
//   tc      out terminal-count pulse
//   ovf     out sticky overflow flag
module counter_channel
  import counter_array_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             c,
  input  logic             rn,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             sat,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));

  cnt_mode_t mode;
  logic      hit;

  assign mode = cnt_mode_t'(sat);

  // A hit is an increment attempt at max that is not pre-empted by clr/ld.
  // In saturate mode the counter stays at max, so every further enabled
  // cycle is another hit and tc stays high.
  assign hit = en && !clr && !ld && (cnt == MAX);

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      cnt <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      tc <= hit;
      // Set wins over clear when both happen on the same edge.
      if (hit)          ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;

      if (clr)                  cnt <= '0;
      else if (ld)              cnt <= ld_val;
      else if (hit)             cnt <= (mode == CNT_SAT) ? MAX : '0;
      else if (en)              cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_array_gen.sv
// Module: counter_array_gen
// Purpose: bank of NCH independent WIDTH-bit event counters with a
//   registered single-channel readout port.
// Ports:
//   c        in  clock, rising edge
//   rn       in  asynchronous reset, active-low
//   en       in  [NCH]        per-channel count enable
//   clr      in  [NCH]        per-channel synchronous clear
//   ld       in  [NCH]        per-channel synchronous load
//   ld_val   in  [WIDTH]      load value shared by all channels
//   sat      in  [NCH]        per-channel mode: 0 = wrap, 1 = saturate
//   ovf_clr  in               clears all sticky overflow flags
//   rd_req   in               readout request
//   rd_sel   in  [SELW]       readout channel index
//   cnt      out [NCH*WIDTH]  counter values, channel i at [i*WIDTH +: WIDTH]
//   tc       out [NCH]        terminal-count pulses
//   ovf      out [NCH]        sticky overflow flags
//   rd_data  out [WIDTH]      readout data (holds when rd_valid is low)
//   rd_valid out              readout valid, one cycle per request
module counter_array_gen
  import counter_array_pkg::*;
#(
  parameter  int NCH   = 8,
  parameter  int WIDTH = 16,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 c,
  input  logic                 rn,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       clr,
  input  logic [NCH-1:0]       ld,
  input  logic [WIDTH-1:0]     ld_val,
  input  logic [NCH-1:0]       sat,
  input  logic                 ovf_clr,
  input  logic                 rd_req,
  input  logic [SELW-1:0]      rd_sel,
  output logic [NCH*WIDTH-1:0] cnt,
  output logic [NCH-1:0]       tc,
  output logic [NCH-1:0]       ovf,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid
);

  localparam int NSEL = 2 ** SELW;

  for (genvar i = 0; i < NCH; i++) begin : gen_ch
    counter_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .c       (c),
      .rn      (rn),
      .en      (en[i]),
      .clr     (clr[i]),
      .ld      (ld[i]),
      .ld_val  (ld_val),
      .sat     (sat[i]),
      .ovf_clr (ovf_clr),
      .cnt     (cnt[i*WIDTH +: WIDTH]),
      .tc      (tc[i]),
      .ovf     (ovf[i])
    );
  end

  // Readout mux padded to the full rd_sel range; indices beyond the last
  // channel read as zero, so no bounds check is needed at the register.
  logic [WIDTH-1:0] rd_mux [NSEL];

  for (genvar j = 0; j < NSEL; j++) begin : gen_rd_mux
    if (j < NCH) begin : g_ch
      assign rd_mux[j] = cnt[j*WIDTH +: WIDTH];
    end else begin : g_pad
      assign rd_mux[j] = '0;
    end
  end

  // ---- readout register stage: captures the pre-update counter value ----
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_mux[rd_sel];
    end
  end

endmodule

// File: tb/tb_counter_array_gen.sv
module tb_counter_array_gen;

  logic        c;
  logic        rn;
  logic [3:0]  en, clr, ld, sat;
  logic [3:0]  ld_val;
  logic        ovf_clr;
  logic        rd_req;
  logic [2:0]  rd_sel5;
  logic [1:0]  rd_sel;
  logic [15:0] cnt;
  logic [3:0]  tc, ovf;
  logic [3:0]  rd_data;
  logic        rd_valid;

  // Second instance with NCH=5 so that an out-of-range rd_sel can be expressed.
  logic [4:0]  en5, clr5, ld5, sat5;
  logic [19:0] cnt5;
  logic [4:0]  tc5, ovf5;
  logic [3:0]  rd_data5;
  logic        rd_valid5;

  assign rd_sel = rd_sel5[1:0];
  assign en5    = {1'b0, en};
  assign clr5   = {1'b0, clr};
  assign ld5    = {1'b0, ld};
  assign sat5   = {1'b0, sat};

  counter_array_gen #(.NCH(4), .WIDTH(4)) u_dut (
    .c(c), .rn(rn), .en(en), .clr(clr), .ld(ld), .ld_val(ld_val), .sat(sat),
    .ovf_clr(ovf_clr), .rd_req(rd_req), .rd_sel(rd_sel), .cnt(cnt), .tc(tc),
    .ovf(ovf), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  counter_array_gen #(.NCH(5), .WIDTH(4)) u_dut5 (
    .c(c), .rn(rn), .en(en5), .clr(clr5), .ld(ld5), .ld_val(ld_val), .sat(sat5),
    .ovf_clr(ovf_clr), .rd_req(rd_req), .rd_sel(rd_sel5), .cnt(cnt5), .tc(tc5),
    .ovf(ovf5), .rd_data(rd_data5), .rd_valid(rd_valid5)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge c);
    #1;
  endtask

  typedef struct {
    logic [3:0]  en, clr, ld, sat, ld_val;
    logic        ovf_clr;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_tc, exp_ovf;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] e, input logic [3:0] cl, input logic [3:0] l,
                              input logic [3:0] s, input logic [3:0] lv, input logic oc,
                              input logic [15:0] ec, input logic [3:0] et, input logic [3:0] eo);
    vec_t v;
    v.en = e; v.clr = cl; v.ld = l; v.sat = s; v.ld_val = lv; v.ovf_clr = oc;
    v.exp_cnt = ec; v.exp_tc = et; v.exp_ovf = eo;
    return v;
  endfunction

  vec_t vecs[15];

  // Reference model state for the random phase
  logic [3:0] m_cnt [4];
  logic [3:0] m_tc, m_ovf;
  logic [3:0] m_rdd;
  logic       m_rdv;

  function automatic logic [15:0] m_cnt_vec();
    return {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
  endfunction

  // Advances the model by one edge using the currently driven inputs.
  task automatic model_edge();
    logic [3:0] nc [4];
    logic [3:0] ntc, novf;
    for (int ch = 0; ch < 4; ch++) begin
      ntc[ch]  = 1'b0;
      novf[ch] = ovf_clr ? 1'b0 : m_ovf[ch];
      if (clr[ch])     nc[ch] = 4'd0;
      else if (ld[ch]) nc[ch] = ld_val;
      else if (en[ch]) begin
        if (m_cnt[ch] == 4'd15) begin
          ntc[ch]  = 1'b1;
          novf[ch] = 1'b1;
          nc[ch]   = sat[ch] ? 4'd15 : 4'd0;
        end else begin
          nc[ch] = m_cnt[ch] + 4'd1;
        end
      end else nc[ch] = m_cnt[ch];
    end
    m_rdv = rd_req;
    if (rd_req) m_rdd = m_cnt[rd_sel];
    for (int ch = 0; ch < 4; ch++) m_cnt[ch] = nc[ch];
    m_tc  = ntc;
    m_ovf = novf;
  endtask

  initial begin
    rn = 1'b0; en = '0; clr = '0; ld = '0; sat = '0; ld_val = '0;
    ovf_clr = 1'b0; rd_req = 1'b0; rd_sel5 = '0;

    vecs[0]  = mk(4'h0, 4'h0, 4'h6, 4'h4, 4'd14, 1'b0, 16'h0EE2, 4'h0, 4'h0);
    vecs[1]  = mk(4'h2, 4'h0, 4'h0, 4'h4, 4'd0,  1'b0, 16'h0EF2, 4'h0, 4'h0);
    vecs[2]  = mk(4'h2, 4'h0, 4'h0, 4'h4, 4'd0,  1'b0, 16'h0E02, 4'h2, 4'h2);
    vecs[3]  = mk(4'h2, 4'h0, 4'h0, 4'h4, 4'd0,  1'b0, 16'h0E12, 4'h0, 4'h2);
    vecs[4]  = mk(4'h4, 4'h0, 4'h0, 4'h4, 4'd0,  1'b0, 16'h0F12, 4'h0, 4'h2);
    vecs[5]  = mk(4'h4, 4'h0, 4'h0, 4'h4, 4'd0,  1'b0, 16'h0F12, 4'h4, 4'h6);
    vecs[6]  = mk(4'h4, 4'h0, 4'h0, 4'h4, 4'd0,  1'b0, 16'h0F12, 4'h4, 4'h6);
    vecs[7]  = mk(4'h4, 4'h0, 4'h0, 4'h4, 4'd0,  1'b0, 16'h0F12, 4'h4, 4'h6);
    vecs[8]  = mk(4'h0, 4'h0, 4'h0, 4'h4, 4'd0,  1'b1, 16'h0F12, 4'h0, 4'h0);
    vecs[9]  = mk(4'h0, 4'h0, 4'h8, 4'h0, 4'd9,  1'b0, 16'h9F12, 4'h0, 4'h0);
    vecs[10] = mk(4'h8, 4'h8, 4'h8, 4'h0, 4'd7,  1'b0, 16'h0F12, 4'h0, 4'h0);
    vecs[11] = mk(4'h8, 4'h0, 4'h8, 4'h0, 4'd7,  1'b0, 16'h7F12, 4'h0, 4'h0);
    vecs[12] = mk(4'h0, 4'h0, 4'h8, 4'h0, 4'd15, 1'b0, 16'hFF12, 4'h0, 4'h0);
    vecs[13] = mk(4'h8, 4'h0, 4'h0, 4'h0, 4'd0,  1'b1, 16'h0F12, 4'h8, 4'h8);
    vecs[14] = mk(4'h0, 4'h8, 4'h0, 4'h0, 4'd0,  1'b0, 16'h0F12, 4'h0, 4'h8);

    // Reset state
    step(); step();
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_tc", 32'(tc), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);

    // Reset mid-count
    rn = 1'b1;
    en = 4'h1; rd_req = 1'b1; rd_sel5 = 3'd0;
    repeat (9) step();
    chk("cnt_before_reset", 32'(cnt), 32'h0009);
    chk("rd_valid_before_reset", 32'(rd_valid), 32'h1);
    #2 rn = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(cnt), 32'h0);
    chk("async_rst_tc", 32'(tc), 32'h0);
    chk("async_rst_ovf", 32'(ovf), 32'h0);
    chk("async_rst_rd_valid", 32'(rd_valid), 32'h0);
    step();
    rn = 1'b1; rd_req = 1'b0;
    step();
    chk("post_rst_cnt1", 32'(cnt), 32'h0001);
    step();
    chk("post_rst_cnt2", 32'(cnt), 32'h0002);
    en = '0;

    // Wrap, saturate, priority: table
    for (int i = 0; i < 15; i++) begin
      en = vecs[i].en; clr = vecs[i].clr; ld = vecs[i].ld; sat = vecs[i].sat;
      ld_val = vecs[i].ld_val; ovf_clr = vecs[i].ovf_clr;
      step();
      chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].exp_tc));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
    end
    en = '0; clr = '0; ld = '0; sat = '0; ovf_clr = 1'b0;

    // Readout: ch1=5, ch2=11
    ld = 4'h2; ld_val = 4'd5;  step();
    ld = 4'h4; ld_val = 4'd11; step();
    ld = 4'h0;
    rd_req = 1'b1; rd_sel5 = 3'd1; step();
    chk("rd1_data", 32'(rd_data), 32'd5);
    chk("rd1_valid", 32'(rd_valid), 32'd1);
    chk("rd1_data5", 32'(rd_data5), 32'd5);
    rd_sel5 = 3'd2; step();
    chk("rd2_data", 32'(rd_data), 32'd11);
    chk("rd2_valid", 32'(rd_valid), 32'd1);
    chk("rd2_data5", 32'(rd_data5), 32'd11);
    rd_sel5 = 3'd6; step();
    chk("rd_oob_data5", 32'(rd_data5), 32'd0);
    chk("rd_oob_valid5", 32'(rd_valid5), 32'd1);
    rd_req = 1'b0; step();
    chk("rd_idle_valid5", 32'(rd_valid5), 32'd0);
    chk("rd_idle_data5", 32'(rd_data5), 32'd0);
    chk("rd_idle_valid", 32'(rd_valid), 32'd0);
    chk("rd_idle_data_hold", 32'(rd_data), 32'd11);
    // Read while the selected channel increments: pre-update value
    rd_req = 1'b1; rd_sel5 = 3'd1; en = 4'h2; step();
    chk("rd_preupd_data", 32'(rd_data), 32'd5);
    chk("rd_preupd_cnt", 32'(cnt[7:4]), 32'd6);
    rd_req = 1'b0; en = '0;

    // Random independence run against the model
    clr = 4'hF; ovf_clr = 1'b1; step();
    clr = 4'h0; ovf_clr = 1'b0; rd_req = 1'b1; rd_sel5 = 3'd0; step();
    for (int ch = 0; ch < 4; ch++) m_cnt[ch] = 4'd0;
    m_tc = '0; m_ovf = '0; m_rdd = '0; m_rdv = 1'b1;
    chk("rnd_init_cnt", 32'(cnt), 32'h0);
    chk("rnd_init_rd", 32'(rd_data), 32'h0);
    for (int k = 0; k < 1000; k++) begin
      en = 4'hF;
      for (int ch = 0; ch < 4; ch++) begin
        clr[ch] = ($urandom_range(0, 11) == 0);
        ld[ch]  = ($urandom_range(0, 9) == 0);
      end
      sat     = 4'($urandom);
      ld_val  = 4'($urandom);
      ovf_clr = ($urandom_range(0, 15) == 0);
      rd_req  = 1'($urandom);
      rd_sel5 = {1'b0, 2'($urandom)};
      model_edge();
      step();
      chk($sformatf("rnd%0d_cnt", k), 32'(cnt), 32'(m_cnt_vec()));
      chk($sformatf("rnd%0d_tc", k), 32'(tc), 32'(m_tc));
      chk($sformatf("rnd%0d_ovf", k), 32'(ovf), 32'(m_ovf));
      chk($sformatf("rnd%0d_rd_valid", k), 32'(rd_valid), 32'(m_rdv));
      chk($sformatf("rnd%0d_rd_data", k), 32'(rd_data), 32'(m_rdd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
